// File: rtl/demux_lane_deserializer.sv
// Collects one routed bit per accepted beat from an 8-way demux into per-lane
// shift registers and emits each completed DATA_W-bit word with its lane tag.
`timescale 1ns/1ps
module demux_lane_deserializer #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        sel,
   input  logic [7:0]        z,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2:0]        out_chan,
   output logic [DATA_W-1:0] out_data,
   output logic              err
);

   localparam int unsigned LANES = 8;
   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   logic [LANES-1:0][DATA_W-1:0] shreg_q, shreg_d;
   logic [LANES-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   logic                         out_valid_q, out_valid_d;
   logic [2:0]                   out_chan_q, out_chan_d;
   logic [DATA_W-1:0]            out_data_q, out_data_d;
   logic                         err_q, err_d;

   logic                         accept_c;
   logic                         bit_c;
   logic                         route_err_c;
   logic [CNT_W-1:0]             cnt_sel_c;
   logic                         done_c;
   logic [DATA_W-1:0]            word_c;

   assign in_ready = ~out_valid_q | out_ready;

   // Beat decode: routed bit, routing check and the word this beat would finish
   always_comb begin
      accept_c    = in_valid & in_ready;
      bit_c       = z[sel];
      route_err_c = |(z & ~(8'b1 << sel));
      cnt_sel_c   = cnt_q[sel];
      done_c      = accept_c && (cnt_sel_c == LAST_CNT);
      word_c      = shreg_q[sel];
      if (LSB_FIRST) begin
         word_c[DATA_W-1] = bit_c;
      end else begin
         word_c = {shreg_q[sel][DATA_W-2:0], bit_c};
      end
   end

   // Next-state: only the selected lane moves; completion bypasses the drain
   always_comb begin
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_chan_d  = out_chan_q;
      out_data_d  = out_data_q;
      err_d       = err_q | (accept_c & route_err_c);

      if (accept_c) begin
         if (done_c) begin
            shreg_d[sel] = '0;
            cnt_d[sel]   = '0;
         end else begin
            if (LSB_FIRST) begin
               shreg_d[sel][cnt_sel_c] = bit_c;
            end else begin
               shreg_d[sel] = {shreg_q[sel][DATA_W-2:0], bit_c};
            end
            cnt_d[sel] = cnt_sel_c + CNT_W'(1);
         end
      end

      if (done_c) begin
         out_valid_d = 1'b1;
         out_chan_d  = sel;
         out_data_d  = word_c;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_chan_q  <= 3'd0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_chan_q  <= out_chan_d;
         out_data_q  <= out_data_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_chan  = out_chan_q;
   assign out_data  = out_data_q;
   assign err       = err_q;

endmodule

// File: tb/tb_demux_lane_deserializer.sv
// Directed bench for demux_lane_deserializer: LSB-first instance for most
// steps, a second MSB-first instance for bit ordering.
`timescale 1ns/1ps
module tb_demux_lane_deserializer;

   logic       clk;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, err;
   logic [2:0] sel, out_chan;
   logic [7:0] z, out_data;

   logic       in_valid1, in_ready1, out_valid1, out_ready1, err1;
   logic [2:0] sel1, out_chan1;
   logic [7:0] z1, out_data1;

   int tests;
   int fails;
   int consumed;
   int c0;
   logic [7:0] pat;

   demux_lane_deserializer #(.DATA_W(8), .LSB_FIRST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .z(z), .out_valid(out_valid), .out_ready(out_ready),
      .out_chan(out_chan), .out_data(out_data), .err(err));

   demux_lane_deserializer #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .sel(sel1), .z(z1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_chan(out_chan1), .out_data(out_data1), .err(err1));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && out_valid && out_ready) consumed <= consumed + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [2:0] s, input logic [7:0] zv);
      in_valid = 1'b1;
      sel      = s;
      z        = zv;
      @(negedge clk);
      in_valid = 1'b0;
      z        = 8'h00;
   endtask

   task automatic beat1(input logic [2:0] s, input logic [7:0] zv);
      in_valid1 = 1'b1;
      sel1      = s;
      z1        = zv;
      @(negedge clk);
      in_valid1 = 1'b0;
      z1        = 8'h00;
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0;
      in_valid = 1'b0; sel = 3'd0; z = 8'h00; out_ready = 1'b1;
      in_valid1 = 1'b0; sel1 = 3'd0; z1 = 8'h00; out_ready1 = 1'b1;
      tests = 0; fails = 0; consumed = 0;
      @(negedge clk); @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_chan", 32'(out_chan), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: lane 3, bits 1,0,1,1,0,0,1,0 LSB first -> 8'h4D
      pat = 8'b0100_1101;
      for (int i = 0; i < 8; i++) begin
         beat(3'd3, pat[i] ? 8'h08 : 8'h00);
         if (i < 7) chk("t1_no_early_valid", 32'(out_valid), 32'd0);
      end
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_chan", 32'(out_chan), 32'd3);
      chk("t1_data", 32'(out_data), 32'h4D);
      chk("t1_err", 32'(err), 32'd0);
      @(negedge clk);
      chk("t1_drain", 32'(out_valid), 32'd0);

      // 2: interleave lanes 0 (all ones) and 7 (all zeros)
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0) beat(3'd0, 8'h01);
         else            beat(3'd7, 8'h00);
         chk("t2_valid", 32'(out_valid), (i >= 14) ? 32'd1 : 32'd0);
         if (i == 14) begin
            chk("t2_chan0", 32'(out_chan), 32'd0);
            chk("t2_data0", 32'(out_data), 32'hFF);
         end
         if (i == 15) begin
            chk("t2_chan7", 32'(out_chan), 32'd7);
            chk("t2_data7", 32'(out_data), 32'h00);
         end
      end
      @(negedge clk);
      chk("t2_drain", 32'(out_valid), 32'd0);

      // 3: backpressure holds output and blocks input
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) beat(3'd4, 8'h10);
      chk("t3_valid", 32'(out_valid), 32'd1);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1; sel = 3'd6; z = 8'h40;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
         chk("t3_hold_valid", 32'(out_valid), 32'd1);
         chk("t3_hold_chan", 32'(out_chan), 32'd4);
         chk("t3_hold_data", 32'(out_data), 32'hFF);
      end
      out_ready = 1'b1;
      #1;
      chk("t3_in_ready_up", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0; z = 8'h00;
      chk("t3_drained", 32'(out_valid), 32'd0);
      for (int i = 0; i < 7; i++) begin
         beat(3'd6, 8'h00);
         if (i < 6) chk("t3_lane6_pending", 32'(out_valid), 32'd0);
      end
      chk("t3_lane6_valid", 32'(out_valid), 32'd1);
      chk("t3_lane6_chan", 32'(out_chan), 32'd6);
      chk("t3_lane6_data", 32'(out_data), 32'h01);

      // 4: routing violation is sticky; lane 0 still records z[0]
      beat(3'd0, 8'b0000_0011);
      chk("t4_err_set", 32'(err), 32'd1);
      for (int i = 0; i < 7; i++) beat(3'd0, 8'h00);
      chk("t4_lane0_chan", 32'(out_chan), 32'd0);
      chk("t4_lane0_data", 32'(out_data), 32'h01);
      for (int i = 0; i < 13; i++) beat(3'd5, 8'h00);
      chk("t4_err_sticky", 32'(err), 32'd1);

      // 5: partial word on lane 2 discarded by async reset
      for (int i = 0; i < 5; i++) beat(3'd2, 8'h04);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) beat(3'd1, 8'h00);
      chk("t5_pre_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_chan", 32'(out_chan), 32'd0);
      chk("t5_rst_data", 32'(out_data), 32'd0);
      chk("t5_rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) beat(3'd2, pat[i] ? 8'h04 : 8'h00);
      chk("t5_valid", 32'(out_valid), 32'd1);
      chk("t5_chan", 32'(out_chan), 32'd2);
      chk("t5_data", 32'(out_data), 32'hA5);
      @(negedge clk);

      // 6: drain and completion in the same cycle
      pat = 8'h3C;
      for (int i = 0; i < 7; i++) beat(3'd3, 8'h00);
      for (int i = 0; i < 7; i++) beat(3'd1, pat[i] ? 8'h02 : 8'h00);
      beat(3'd3, 8'h00);
      chk("t6_lane3_valid", 32'(out_valid), 32'd1);
      chk("t6_lane3_chan", 32'(out_chan), 32'd3);
      c0 = consumed;
      beat(3'd1, pat[7] ? 8'h02 : 8'h00);
      chk("t6_valid_kept", 32'(out_valid), 32'd1);
      chk("t6_chan", 32'(out_chan), 32'd1);
      chk("t6_data", 32'(out_data), 32'h3C);
      chk("t6_consumed_once", 32'(consumed - c0), 32'd1);
      @(negedge clk);
      chk("t6_consumed_total", 32'(consumed - c0), 32'd2);
      chk("t6_drain", 32'(out_valid), 32'd0);

      // 7: MSB-first instance, bits 1,0,1,1,0,0,1,0 -> 8'hB2
      pat = 8'b0100_1101;
      for (int i = 0; i < 8; i++) beat1(3'd5, pat[i] ? 8'h20 : 8'h00);
      chk("t7_valid", 32'(out_valid1), 32'd1);
      chk("t7_chan", 32'(out_chan1), 32'd5);
      chk("t7_data", 32'(out_data1), 32'hB2);
      chk("t7_err", 32'(err1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/demux_lane_deserializer.md
Name: demux_lane_deserializer

Overview:
- Sits directly downstream of the 1-to-8 bit demultiplexer (`din`, `sel[2:0]` in; `z[7:0]` out).
- Consumes one routed bit per accepted beat from `z[sel]` and keeps an independent shift register per lane.
- When a lane has collected DATA_W bits, it emits the word with its lane number over a valid/ready interface.
- Also flags demux outputs that violate one-hot-or-zero routing.

Parameters:
- DATA_W, 8, bits per assembled word; legal range 2..32.
- LSB_FIRST, 1, 1: first received bit lands in out_data[0]; 0: first received bit lands in out_data[DATA_W-1].

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a beat is present on sel/z this cycle.
- in_ready  output  1  block can accept a beat this cycle.
- sel  input  3  lane select driven to the demux, same cycle as z.
- z  input  8  demux outputs; only z[sel] may carry data.
- out_valid  output  1  out_chan/out_data hold a completed word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_chan  output  3  lane the word was assembled on.
- out_data  output  DATA_W  assembled word.
- err  output  1  sticky: a routing violation was seen.

Behaviour:
- Reset (async assert, sync release):
  - All 8 lane shift registers and bit counters clear to 0.
  - out_valid=0, out_chan=0, out_data=0, err=0.
  - A partial word in progress at reset is discarded.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - A beat is accepted iff in_valid & in_ready.
  - Non-accepted beats change no state, including err.
- Bit extraction: on accept, b = z[sel].
- Error detection: if any z[i] with i != sel is 1 on an accepted beat, err sets.
  - b is still taken from z[sel].
  - err stays set until reset.
- Lane update on accept; only lane sel changes, count = cnt[sel]:
  - LSB_FIRST=1: shreg[sel][count] <= b.
  - LSB_FIRST=0: shreg[sel] <= {shreg[sel][DATA_W-2:0], b}.
  - count < DATA_W-1: cnt[sel] increments.
  - count == DATA_W-1: word complete (see below).
- On word completion:
  - The word is formed from the stored bits plus b.
  - It loads out_data and out_chan=sel on the same edge; out_valid=1 from the next cycle.
  - Latency from the last accepted bit to out_valid is 1 clock.
  - cnt[sel] wraps to 0; shreg[sel] clears.
- Output hold and drain:
  - While out_valid & ~out_ready, out_chan/out_data/out_valid are held stable.
  - out_valid & out_ready with no completion this cycle: out_valid <= 0; data registers may hold their stale value.
  - out_valid & out_ready with a completion this cycle: the new word loads and out_valid stays 1. No bubble and no drop.
- Lane independence: beats to other lanes never alter a lane's count or bits; interleaving is arbitrary.
- Capacity: at most one completion per cycle, so a single output register suffices. No overflow path exists.
- sel is always in range for 8 lanes; there are no X/illegal-lane cases.

Test Plan:
1. DATA_W=8, LSB_FIRST=1, out_ready=1; 8 beats on lane 3 with z[3] = 1,0,1,1,0,0,1,0 (other z=0) -> one cycle after beat 8: out_valid=1, out_chan=3, out_data=8'h4D, err=0.
2. Alternating lanes 0 and 7 for 16 beats; lane 0 bits all 1, lane 7 bits all 0 -> out_chan=0/out_data=8'hFF one cycle after beat 15; out_chan=7/out_data=8'h00 one cycle after beat 16; no other words.
3. Complete a word with out_ready=0, then hold in_valid=1 for 5 cycles -> in_ready=0 and the output is stable for those cycles; raise out_ready -> the word drains and beats are accepted from that cycle.
4. Accepted beat with sel=0, z=8'b0000_0011 -> err=1 and stays 1 through 20 further clean beats; lane 0 records bit 1.
5. 5 beats to lane 2, pulse rst_n low mid-cycle -> all outputs go 0 immediately; then 8 beats of pattern 8'hA5 to lane 2 -> out_data=8'hA5 exactly.
6. out_valid=1 with out_ready=1 in the same cycle that lane 1 completes 8'h3C -> out_valid stays 1, the next cycle shows out_chan=1, out_data=8'h3C, and the prior word counts as consumed once.
7. LSB_FIRST=0; 8 beats on lane 5 with bits 1,0,1,1,0,0,1,0 -> out_data=8'hB2.
